sram_mem_stage: RTL and testbench
=================================

SRAM_MEM_STAGE -- requirements
Module: sram_mem_stage

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 5: SRAM cycles per bus transfer (legal 1..15).
REQ-002 The block SHALL have parameter ADDR_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 The block SHALL have parameter SRAM_AW, default 17: SRAM word-address width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports named as follows:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
REQ-005 The block SHALL have the following pipeline-side ports:
 wb_en_in  in  1  write-back enable from EXE register
 mem_r_en_in  in  1  load request
 mem_w_en_in  in  1  store request
 alu_result_in  in  32  byte address or ALU value
 val_rm_in  in  32  store data
 dest_in  in  4  destination register
 wb_en_out  out  1  to MEM register
 mem_r_en_out  out  1  to MEM register
 alu_result_out  out  32  to MEM register
 mem_rdata  out  32  load data to MEM register
 dest_out  out  4  to MEM register
 ready  out  1  0 = freeze entire pipeline
REQ-006 The block SHALL have the following SRAM-side ports:
 sram_addr  out  SRAM_AW  word address
 sram_wdata  out  DW  write data (DW=32, or 16 with SRAM_DATA16_EN)
 sram_rdata  in  DW  read data
 sram_we_n  out  1  active-low write strobe

Function
REQ-007 The block SHALL pass wb_en, mem_r_en, alu_result and dest combinationally from input to output.
REQ-008 The block SHALL compute the word address as (alu_result_in - ADDR_BASE) >> 2, truncated to SRAM_AW bits, and latch it at request acceptance.
REQ-009 The FSM SHALL have states IDLE, ACCESS, DONE (plus ACCESS_HI under SRAM_DATA16_EN).
REQ-010 In IDLE with mem_r_en_in or mem_w_en_in high, the block SHALL latch address and store data, drive ready=0 combinationally in that same cycle, and enter ACCESS.
REQ-011 If both enables are high, the block SHALL perform a read only.
REQ-012 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter, with ready=0 throughout.
REQ-013 sram_we_n SHALL be low in every ACCESS cycle of a write and high at all other times.
REQ-014 For a read, the block SHALL sample sram_rdata into mem_rdata on the last ACCESS cycle.
REQ-015 DONE SHALL last one cycle with ready=1, SHALL ignore the still-present request, and SHALL then return to IDLE.
REQ-016 Total freeze SHALL be WAIT_CYCLES+1 cycles per access (2*WAIT_CYCLES+1 in 16-bit mode).
REQ-017 In IDLE without a request, ready SHALL be 1 and mem_rdata SHALL hold its last value.
REQ-018 Back-to-back memory instructions SHALL each be accepted only from IDLE, with no lost or repeated access.

Reset
REQ-019 On rst, the block SHALL set the FSM to IDLE, the counter to 0, mem_rdata to 0, sram_we_n to 1, and sram_addr/sram_wdata to 0, effective at the next edge.
REQ-020 rst during ACCESS SHALL abort the transfer with no further write strobe; ready SHALL be 1 after reset unless a new request is present.

Configuration
REQ-021 With SRAM_DATA16_EN defined, DW SHALL be 16, and each access SHALL perform ACCESS (low half, sram_addr = word*2) then ACCESS_HI (high half, word*2+1), each WAIT_CYCLES long.
REQ-022 With SRAM_DATA16_EN defined, mem_rdata SHALL be assembled {hi,lo} and SRAM_AW SHALL be widened by 1.
REQ-023 Without SRAM_DATA16_EN, DW SHALL be 32 with a single transfer.

Structure
REQ-024 Package sram_pkg SHALL hold the state enum, the default ADDR_BASE and the default WAIT_CYCLES.
REQ-025 The wait counter SHALL be one sub-module, sram_wait_timer (load, count-down, last-cycle flag).

Verification
REQ-026 Load at alu_result_in=1032, WAIT_CYCLES=5, sram_rdata=0xDEADBEEF -> sram_addr=2, ready low 6 cycles, mem_rdata=0xDEADBEEF in DONE.
REQ-027 Store 0x12345678 to 1028 -> sram_we_n low exactly 5 cycles, sram_addr=1, sram_wdata=0x12345678.
REQ-028 Non-memory instruction (alu_result_in=7, wb_en_in=1) -> ready stays 1, outputs pass through same cycle.
REQ-029 Two consecutive loads to 1024 and 1028 -> two distinct 6-cycle freezes, addresses 0 then 1, one DONE cycle between.
REQ-030 rst asserted at 3rd ACCESS cycle of a store -> sram_we_n high next cycle, FSM IDLE, mem_rdata=0.
REQ-031 SRAM_DATA16_EN, load 1024, halves 0xBEEF then 0xDEAD -> addresses 0,1, ready low 11 cycles, mem_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, bus widths and defaults for the SRAM memory stage.
// Build option: define SRAM_DATA16_EN for a 16-bit SRAM data bus. Each access is then
// split into a low half and a high half, and the SRAM word address gains one bit.
package sram_pkg;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 32'd5;
  localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'd1024;

  // Wait counter width; covers the legal WAIT_CYCLES range 1..15
  localparam int unsigned CNT_W = 32'd4;

`ifdef SRAM_DATA16_EN
  localparam int unsigned DW       = 32'd16;
  localparam int unsigned ADDR_EXT = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_ACCESS_HI = 2'd2,
    ST_DONE      = 2'd3
  } state_e;
`else
  localparam int unsigned DW       = 32'd32;
  localparam int unsigned ADDR_EXT = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;
`endif

  // Word index of a byte address relative to the SRAM window base (not yet truncated)
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer: loadable down-counter that times one SRAM transfer phase.
// last_o is high in the final cycle of the phase (count equal to one).
module sram_wait_timer
  import sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sram_mem_stage.sv
// sram_mem_stage: pipeline MEM stage in front of an asynchronous SRAM.
// A load or store seen in IDLE freezes the pipeline (ready low) while the SRAM is
// held for WAIT_CYCLES cycles per transfer, then a single DONE cycle releases it.
// Build option SRAM_DATA16_EN: 16-bit SRAM bus, low half then high half per access.
module sram_mem_stage
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_AW     = 32'd17
) (
  input  logic                        clk,
  input  logic                        rst,
  // pipeline side
  input  logic                        wb_en_in,
  input  logic                        mem_r_en_in,
  input  logic                        mem_w_en_in,
  input  logic [31:0]                 alu_result_in,
  input  logic [31:0]                 val_rm_in,
  input  logic [3:0]                  dest_in,
  output logic                        wb_en_out,
  output logic                        mem_r_en_out,
  output logic [31:0]                 alu_result_out,
  output logic [31:0]                 mem_rdata,
  output logic [3:0]                  dest_out,
  output logic                        ready,
  // SRAM side
  output logic [SRAM_AW+ADDR_EXT-1:0] sram_addr,
  output logic [DW-1:0]               sram_wdata,
  input  logic [DW-1:0]               sram_rdata,
  output logic                        sram_we_n
);

  localparam int unsigned AW = SRAM_AW + ADDR_EXT;

  state_e              state_q;
  logic [AW-1:0]       sram_addr_q;
  logic [DW-1:0]       sram_wdata_q;
  logic                sram_we_n_q;
  logic [31:0]         mem_rdata_q;
  logic                is_write_q;

`ifdef SRAM_DATA16_EN
  logic [SRAM_AW-1:0]  word_q;
  logic [15:0]         wdata_hi_q;
  logic [15:0]         rdata_lo_q;
`endif

  logic                req_s;
  logic                wr_req_s;
  logic                ready_s;
  logic                tmr_load_s;
  logic                tmr_dec_s;
  logic                tmr_last_s;
  logic [SRAM_AW-1:0]  word_s;

  // Non-memory fields flow straight through to the MEM register
  assign wb_en_out      = wb_en_in;
  assign mem_r_en_out   = mem_r_en_in;
  assign alu_result_out = alu_result_in;
  assign dest_out       = dest_in;

  // A request with both enables set is treated as a read only
  assign req_s    = mem_r_en_in | mem_w_en_in;
  assign wr_req_s = mem_w_en_in & ~mem_r_en_in;
  assign word_s   = SRAM_AW'(word_index(alu_result_in, ADDR_BASE));

  // Pipeline release: free in idle without a request and in the DONE cycle
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_DONE: ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Wait timer control: arm on acceptance (and between halves), count down while accessing
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          tmr_load_s = 1'b1;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_ACCESS: begin
`ifdef SRAM_DATA16_EN
        if (tmr_last_s) begin
          tmr_load_s = 1'b1;
        end else begin
          tmr_dec_s = 1'b1;
        end
`else
        tmr_dec_s = 1'b1;
`endif
      end
`ifdef SRAM_DATA16_EN
      ST_ACCESS_HI: tmr_dec_s = 1'b1;
`endif
      default: begin
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
      end
    endcase
  end

  sram_wait_timer u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (CNT_W'(WAIT_CYCLES)),
    .dec_i      (tmr_dec_s),
    .last_o     (tmr_last_s)
  );

  // Access sequencer: latches the request, drives the SRAM strobe and captures load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sram_addr_q  <= {AW{1'b0}};
      sram_wdata_q <= {DW{1'b0}};
      sram_we_n_q  <= 1'b1;
      mem_rdata_q  <= 32'h0000_0000;
      is_write_q   <= 1'b0;
`ifdef SRAM_DATA16_EN
      word_q       <= {SRAM_AW{1'b0}};
      wdata_hi_q   <= 16'h0000;
      rdata_lo_q   <= 16'h0000;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            is_write_q  <= wr_req_s;
            sram_we_n_q <= ~wr_req_s;
`ifdef SRAM_DATA16_EN
            word_q       <= word_s;
            sram_addr_q  <= {word_s, 1'b0};
            sram_wdata_q <= val_rm_in[15:0];
            wdata_hi_q   <= val_rm_in[31:16];
`else
            sram_addr_q  <= word_s;
            sram_wdata_q <= val_rm_in;
`endif
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (tmr_last_s) begin
`ifdef SRAM_DATA16_EN
            if (!is_write_q) begin
              rdata_lo_q <= sram_rdata;
            end
            sram_addr_q  <= {word_q, 1'b1};
            sram_wdata_q <= wdata_hi_q;
            state_q      <= ST_ACCESS_HI;
`else
            if (!is_write_q) begin
              mem_rdata_q <= sram_rdata;
            end
            sram_we_n_q <= 1'b1;
            state_q     <= ST_DONE;
`endif
          end
        end
`ifdef SRAM_DATA16_EN
        ST_ACCESS_HI: begin
          if (tmr_last_s) begin
            if (!is_write_q) begin
              mem_rdata_q <= {sram_rdata, rdata_lo_q};
            end
            sram_we_n_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
`endif
        // The request is still visible here; it is ignored until IDLE is reached
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          sram_we_n_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_we_n  = sram_we_n_q;
  assign mem_rdata  = mem_rdata_q;
  assign ready      = ready_s;

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb_sram_mem_stage: randomized bench for sram_mem_stage with a transaction-level
// reference (expected freeze length, address/strobe per access cycle, memory contents).
module tb_sram_mem_stage;
  import sram_pkg::*;

  localparam int unsigned W      = 32'd5;
  localparam int unsigned AWB    = 32'd17;
  localparam int unsigned HALVES = (DW == 32'd16) ? 32'd2 : 32'd1;
  localparam int unsigned FREEZE = HALVES * W + 32'd1;
  localparam logic [31:0] WMASK  = (32'd1 << AWB) - 32'd1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0]             alu_result_in, val_rm_in;
  logic [3:0]              dest_in;
  logic                    wb_en_out, mem_r_en_out, ready;
  logic [31:0]             alu_result_out, mem_rdata;
  logic [3:0]              dest_out;
  logic [AWB+ADDR_EXT-1:0] sram_addr;
  logic [DW-1:0]           sram_wdata;
  logic [DW-1:0]           sram_rdata;
  logic                    sram_we_n;
  logic                    mem_clr;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: words written by completed stores; unwritten words read as DEADBEEF
  logic [31:0]  ref_mem [0:255];
  logic [255:0] ref_ok;
  logic [31:0]  last_rdata;

  // Behavioural SRAM
  logic [DW-1:0] sram_mem [0:255];
  logic [255:0]  sram_wr;

  always #5 clk = ~clk;

  sram_mem_stage #(
    .WAIT_CYCLES (W),
    .ADDR_BASE   (32'd1024),
    .SRAM_AW     (AWB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .alu_result_in  (alu_result_in),
    .val_rm_in      (val_rm_in),
    .dest_in        (dest_in),
    .wb_en_out      (wb_en_out),
    .mem_r_en_out   (mem_r_en_out),
    .alu_result_out (alu_result_out),
    .mem_rdata      (mem_rdata),
    .dest_out       (dest_out),
    .ready          (ready),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .sram_we_n      (sram_we_n)
  );

  function automatic logic [DW-1:0] init_half(input logic odd);
    if (DW == 32'd16) return odd ? DW'(32'h0000DEAD) : DW'(32'h0000BEEF);
    else return DW'(32'hDEADBEEF);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] word);
    if (ref_ok[word[7:0]]) return ref_mem[word[7:0]];
    else return 32'hDEADBEEF;
  endfunction

  // SRAM write port
  always @(posedge clk) begin
    if (mem_clr) sram_wr <= '0;
    else if (sram_we_n === 1'b0) begin
      sram_mem[sram_addr[7:0]] <= sram_wdata;
      sram_wr[sram_addr[7:0]]  <= 1'b1;
    end
  end

  // SRAM read port: data valid mid-cycle for the address presented this cycle
  always @(negedge clk) begin
    if (sram_wr[sram_addr[7:0]] === 1'b1) sram_rdata <= sram_mem[sram_addr[7:0]];
    else sram_rdata <= init_half(sram_addr[0]);
  end

  // One memory instruction; entered and left just after a rising edge
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic keep);
    logic [31:0] word, exp_rd, exp_addr, exp_wd;
    logic        is_wr;
    int          frz, we_lo, k;
    bit          done;
    word   = ((addr - 32'd1024) >> 2) & WMASK;
    is_wr  = wr & ~rd;
    exp_rd = ref_read(word);
    mem_r_en_in = rd; mem_w_en_in = wr; alu_result_in = addr; val_rm_in = wdat;
    wb_en_in = rd; dest_in = 4'($urandom);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL accept_ready: got %b want 0", ready); end
    n_vec++;
    if (alu_result_out !== addr || mem_r_en_out !== rd) begin
      n_err++; $display("FAIL accept_pass: got %h/%b want %h/%b", alu_result_out, mem_r_en_out, addr, rd);
    end
    frz = 1; we_lo = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (ready === 1'b1) done = 1;
      else begin
        frz++;
        k = frz - 1;
        if (sram_we_n === 1'b0) we_lo++;
        if (HALVES == 32'd1) exp_addr = word;
        else exp_addr = word * 32'd2 + ((k > int'(W)) ? 32'd1 : 32'd0);
        n_vec++;
        if (32'(sram_addr) !== exp_addr) begin
          n_err++; $display("FAIL access_addr cyc %0d: got %h want %h", k, sram_addr, exp_addr);
        end
        if (is_wr) begin
          if (HALVES == 32'd1) exp_wd = wdat;
          else exp_wd = (k > int'(W)) ? {16'd0, wdat[31:16]} : {16'd0, wdat[15:0]};
          n_vec++;
          if (32'(sram_wdata) !== exp_wd) begin
            n_err++; $display("FAIL access_wdata cyc %0d: got %h want %h", k, sram_wdata, exp_wd);
          end
        end
      end
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL ready_timeout: got ready=%b want 1 within 64 cycles", ready); end
    n_vec++;
    if (frz != int'(FREEZE)) begin n_err++; $display("FAIL freeze_len: got %0d want %0d", frz, FREEZE); end
    n_vec++;
    if (we_lo != (is_wr ? int'(FREEZE) - 1 : 0)) begin
      n_err++; $display("FAIL we_low_cycles: got %0d want %0d", we_lo, is_wr ? int'(FREEZE) - 1 : 0);
    end
    n_vec++;
    if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL we_done: got %b want 1", sram_we_n); end
    if (!is_wr) begin
      n_vec++;
      if (mem_rdata !== exp_rd) begin n_err++; $display("FAIL load_data: got %h want %h", mem_rdata, exp_rd); end
      last_rdata = exp_rd;
    end else begin
      ref_mem[word[7:0]] = wdat;
      ref_ok[word[7:0]]  = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep) begin mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_vec++; if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b want 1", sram_we_n); end
    n_vec++; if (32'(sram_addr) !== 32'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
    n_vec++; if (32'(sram_wdata) !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", sram_wdata); end
    last_rdata = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      wb_en_in = (i == 0) ? 1'b1 : 1'($urandom);
      mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      alu_result_in = (i == 0) ? 32'd7 : $urandom;
      dest_in = 4'($urandom);
      #1;
      n_vec++;
      if (wb_en_out !== wb_en_in || alu_result_out !== alu_result_in || dest_out !== dest_in || mem_r_en_out !== 1'b0) begin
        n_err++; $display("FAIL pass_fields: got %b/%h/%h want %b/%h/%h", wb_en_out, alu_result_out, dest_out, wb_en_in, alu_result_in, dest_in);
      end
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1) begin n_err++; $display("FAIL pass_ready: got %b/%b want 1/1", ready, sram_we_n); end
      n_vec++;
      if (mem_rdata !== last_rdata) begin n_err++; $display("FAIL pass_hold: got %h want %h", mem_rdata, last_rdata); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    run_txn(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0);
    run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);
    run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
  endtask

  task automatic test_both_enables();
    run_txn(1'b1, 1'b1, 32'd1036, $urandom, 1'b0);
    run_txn(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0);
  endtask

  task automatic test_addr_boundary();
    run_txn(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0);
    run_txn(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) begin
      op   = int'($urandom_range(2, 0));
      addr = 32'd1024 + 32'($urandom_range(31, 0)) * 32'd4 + 32'($urandom_range(3, 0));
      run_txn(op != 1, op != 0, addr, $urandom, (i != 15) ? 1'($urandom) : 1'b0);
    end
  endtask

  task automatic test_reset_mid_access();
    int we_lo;
    run_txn(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0);
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_result_in = 32'd1024 + 32'd60 * 32'd4; val_rm_in = $urandom;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL abort_pre: got %b want 0", sram_we_n); end
    @(posedge clk); #1;
    rst = 1'b0; mem_w_en_in = 1'b0;
    @(negedge clk);
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL abort_we_n: got %b want 1", sram_we_n); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", ready); end
    n_vec++; if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL abort_rdata: got %h want 0", mem_rdata); end
    n_vec++; if (32'(sram_addr) !== 32'd0) begin n_err++; $display("FAIL abort_addr: got %h want 0", sram_addr); end
    we_lo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sram_we_n !== 1'b1 || ready !== 1'b1) we_lo++;
    end
    n_vec++; if (we_lo != 0) begin n_err++; $display("FAIL abort_quiet: got %0d busy cycles want 0", we_lo); end
    last_rdata = 32'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    ref_ok = '0;
    last_rdata = 32'd0;
    rst = 1'b1; mem_clr = 1'b1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_result_in = 32'd0; val_rm_in = 32'd0; dest_in = 4'd0;
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_back_to_back();
    test_both_enables();
    test_addr_boundary();
    test_random();
    test_passthrough();
    test_reset_mid_access();
    test_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule
